// File: rtl/qtree_int_stream_tx_if.sv
// qtree_int_stream_tx_if: root handoff, heap read port and output stream of the QTree serializer
interface qtree_int_stream_tx_if #(
  parameter int PTR_W  = 16,
  parameter int NODE_W = 66
);
  logic              root_valid;
  logic              root_ready;
  logic [PTR_W-1:0]  root_ptr;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [PTR_W-1:0]  rd_req_addr;
  logic              rd_rsp_valid;
  logic [NODE_W-1:0] rd_rsp_data;
  logic [NODE_W-1:0] o_tdata;
  logic              o_tvalid;
  logic              o_tready;
  logic              o_tlast;
  modport master (
    input  root_valid, root_ptr, rd_req_ready, rd_rsp_valid, rd_rsp_data, o_tready,
    output root_ready, rd_req_valid, rd_req_addr, o_tdata, o_tvalid, o_tlast
  );
  modport slave (
    output root_valid, root_ptr, rd_req_ready, rd_rsp_valid, rd_rsp_data, o_tready,
    input  root_ready, rd_req_valid, rd_req_addr, o_tdata, o_tvalid, o_tlast
  );
endinterface

// File: rtl/qtree_int_stream_tx.sv
// qtree_int_stream_tx: walks a heap-resident QTree Int depth-first and streams its nodes in post-order
module qtree_int_stream_tx #(
  parameter int PTR_W  = 16,
  parameter int VAL_W  = 32,
  parameter int NODE_W = 66,
  parameter int DEPTH  = 64
) (
  input  logic                 clk,
  input  logic                 aresetn,
  qtree_int_stream_tx_if.master bus,
  output logic                 busy,
  output logic                 err_overflow
);
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int IX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if (NODE_W < VAL_W + 2 || NODE_W < 66) begin : g_width_check
    $error("NODE_W cannot hold the tag plus four child pointers or the value");
  end
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, NEXT, EMIT} state_t;
  state_t state, state_nx;
  logic [SP_W-1:0]   sp;
  logic [PTR_W-1:0]  cur_ptr;
  logic [NODE_W-1:0] tdata;
  logic [NODE_W-3:0] kids [DEPTH];
  logic [2:0]        rem  [DEPTH];
  logic [IX_W-1:0]   top, push_ix;
  logic [2:0]        cur_rem;
  logic [1:0]        idx, tag;
  logic [15:0]       child;
  logic              full, last;
  assign top     = IX_W'(sp - 1'b1);
  assign push_ix = IX_W'(sp);
  assign cur_rem = rem[top];
  assign idx     = 2'(cur_rem - 3'd1);
  assign child   = kids[top][{idx, 4'b0000} +: 16];
  assign full    = sp == SP_W'(DEPTH);
  assign tag     = bus.rd_rsp_data[1:0];
  assign last    = state == EMIT && sp == '0;
  assign bus.root_ready   = state == IDLE;
  assign bus.rd_req_valid = state == FETCH;
  assign bus.rd_req_addr  = cur_ptr;
  assign bus.o_tvalid     = state == EMIT;
  assign bus.o_tlast      = last;
  assign bus.o_tdata      = tdata;
  assign busy             = state != IDLE;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.root_valid ? FETCH : IDLE;
      FETCH:   state_nx = bus.rd_req_ready ? WAIT : FETCH;
      WAIT:    state_nx = !bus.rd_rsp_valid ? WAIT : tag != 2'd2 ? EMIT : full ? IDLE : NEXT;
      NEXT:    state_nx = cur_rem != 3'd0 ? FETCH : EMIT;
      EMIT:    state_nx = !bus.o_tready ? EMIT : last ? IDLE : NEXT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sp           <= '0;
      cur_ptr      <= '0;
      tdata        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (state == IDLE && bus.root_valid) begin
        cur_ptr      <= bus.root_ptr;
        sp           <= '0;
        err_overflow <= 1'b0;
      end
      if (state == WAIT && bus.rd_rsp_valid) begin
        if (tag != 2'd2) tdata <= bus.rd_rsp_data;
        else if (full) begin
          err_overflow <= 1'b1;
          sp           <= '0;
        end else sp <= sp + 1'b1;
      end
      // children are taken c3 first so c0 is the last subtree emitted before its parent
      if (state == NEXT) begin
        if (cur_rem != 3'd0) cur_ptr <= PTR_W'(child);
        else begin
          tdata <= NODE_W'(2'd2);
          sp    <= sp - 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == WAIT && bus.rd_rsp_valid && tag == 2'd2 && !full) begin
      kids[push_ix] <= bus.rd_rsp_data[NODE_W-1:2];
      rem[push_ix]  <= 3'd4;
    end else if (state == NEXT && cur_rem != 3'd0) rem[top] <= cur_rem - 3'd1;
  end
endmodule

// File: tb/tb_qtree_int_stream_tx.sv
// tb_qtree_int_stream_tx: heap model plus table of trees and their expected post-order streams
module tb_qtree_int_stream_tx;
  localparam int PW = 16, NW = 66, D = 2;
  localparam logic [65:0] NODEW = 66'd2;
  logic clk = 0, aresetn = 0;
  always #5 clk = ~clk;
  logic busy, err_overflow;
  qtree_int_stream_tx_if #(.PTR_W(PW), .NODE_W(NW)) bus();
  qtree_int_stream_tx #(.PTR_W(PW), .VAL_W(32), .NODE_W(NW), .DEPTH(D)) dut (
    .clk(clk), .aresetn(aresetn), .bus(bus), .busy(busy), .err_overflow(err_overflow)
  );
  typedef struct {logic [15:0] root; int stall; logic ovf; int first; int nw;} case_t;
  typedef struct {logic [65:0] d; logic l;} word_t;
  case_t ctab[7];
  word_t wtab[$], expq[$], w;
  logic [15:0] addrq[$];
  logic [65:0] heap [64];
  int nvec = 0, nerr = 0, widx = 0;
  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [65:0] qv(input logic [31:0] v);
    return {32'b0, v, 2'd1};
  endfunction
  function automatic logic [65:0] qn(input logic [15:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0, 2'd2};
  endfunction
  function automatic void add(input logic [65:0] d, input logic l);
    wtab.push_back('{d: d, l: l});
  endfunction
  // heap: one-cycle read latency, response pulse follows each accepted request
  logic m_v = 0, inj_v = 0;
  logic [65:0] m_d = '0, inj_d = '0;
  always @(posedge clk) begin
    m_v <= bus.rd_req_valid && bus.rd_req_ready;
    m_d <= heap[bus.rd_req_addr[5:0]];
  end
  assign bus.rd_rsp_valid = m_v | inj_v;
  assign bus.rd_rsp_data  = inj_v ? inj_d : m_d;
  logic pend = 0, pl = 0, lastseen = 0, leafrsp = 0;
  logic [65:0] pd = '0;
  always @(negedge clk) begin
    if (!aresetn) begin
      pend = 0; lastseen = 0; leafrsp = 0;
    end else begin
      if (lastseen) chk("ready_after_last", bus.root_ready, 1'b1);
      if (leafrsp) chk("leaf_rsp_latency", bus.o_tvalid, 1'b1);
      if (pend) begin
        chk("hold_valid", bus.o_tvalid, 1'b1);
        chk("hold_data", bus.o_tdata, pd);
        chk("hold_last", bus.o_tlast, pl);
      end
      if (bus.o_tvalid) chk("no_req_while_pending", bus.rd_req_valid, 1'b0);
      if (bus.rd_req_valid && bus.rd_req_ready) addrq.push_back(bus.rd_req_addr);
      lastseen = 0;
      if (bus.o_tvalid && bus.o_tready) begin
        if (expq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_word: got %h expected none", bus.o_tdata);
        end else begin
          w = expq.pop_front();
          chk("word", bus.o_tdata, w.d);
          chk("tlast", bus.o_tlast, w.l);
        end
        widx++;
        lastseen = bus.o_tlast;
      end
      pend = bus.o_tvalid && !bus.o_tready;
      pd = bus.o_tdata;
      pl = bus.o_tlast;
      leafrsp = busy && bus.rd_rsp_valid && bus.rd_rsp_data[1:0] != 2'd2;
    end
  end
  task automatic run(input logic [15:0] ptr, input int stall_at, input logic exp_ovf);
    int cyc = 0, sc = 0;
    @(posedge clk); #1;
    bus.root_valid = 1; bus.root_ptr = ptr;
    @(negedge clk);
    chk("root_ready_idle", bus.root_ready, 1'b1);
    @(posedge clk); #1;
    bus.root_valid = 0;
    @(negedge clk);
    chk("first_req_latency", bus.rd_req_valid, 1'b1);
    chk("busy_after_accept", busy, 1'b1);
    chk("ovf_cleared", err_overflow, 1'b0);
    while (busy && cyc < 3000) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && widx == stall_at && bus.o_tvalid && sc < 3) begin
        bus.o_tready = 0; sc++;
      end else bus.o_tready = 1;
      @(negedge clk);
      cyc++;
    end
    bus.o_tready = 1;
    if (busy) begin
      nvec++; nerr++;
      $display("FAIL timeout: got busy after %0d cycles expected idle", cyc);
    end
    chk("err_overflow", err_overflow, exp_ovf);
    chk("idle_ready", bus.root_ready, 1'b1);
  endtask
  initial begin
    logic [15:0] ea [5];
    int cyc;
    ea = '{16'd10, 16'd14, 16'd13, 16'd12, 16'd11};
    for (int i = 0; i < 64; i++) heap[i] = '0;
    heap[5]  = qv(42);
    heap[10] = qn(11, 12, 13, 14);
    for (int i = 0; i < 4; i++) heap[11+i] = qv(32'(i + 1));
    heap[20] = qn(21, 22, 23, 24);
    heap[21] = {64'h1234, 2'd0};
    heap[22] = {64'hABCD_0000_5555, 2'd3};
    heap[23] = qv(32'hFFFF_FFF9);
    heap[24] = {64'h0, 2'd0};
    heap[30] = qn(31, 31, 31, 31);
    heap[31] = qn(32, 32, 32, 32);
    heap[32] = qn(33, 33, 33, 33);
    heap[33] = qv(9);
    heap[40] = qn(41, 41, 41, 41);
    heap[41] = qn(42, 43, 44, 45);
    for (int i = 0; i < 4; i++) heap[42+i] = qv(32'(100 + i));
    ctab[0] = '{root: 5,  stall: -1, ovf: 0, first: wtab.size(), nw: 1};
    add(qv(42), 1);
    ctab[1] = '{root: 10, stall: -1, ovf: 0, first: wtab.size(), nw: 5};
    add(qv(4), 0); add(qv(3), 0); add(qv(2), 0); add(qv(1), 0); add(NODEW, 1);
    ctab[2] = '{root: 10, stall: 1,  ovf: 0, first: ctab[1].first, nw: 5};
    ctab[3] = '{root: 20, stall: -1, ovf: 0, first: wtab.size(), nw: 5};
    add({64'h0, 2'd0}, 0); add(qv(32'hFFFF_FFF9), 0);
    add({64'hABCD_0000_5555, 2'd3}, 0); add({64'h1234, 2'd0}, 0); add(NODEW, 1);
    ctab[4] = '{root: 30, stall: -1, ovf: 1, first: 0, nw: 0};
    ctab[5] = '{root: 5,  stall: -1, ovf: 0, first: ctab[0].first, nw: 1};
    ctab[6] = '{root: 40, stall: 7,  ovf: 0, first: wtab.size(), nw: 21};
    for (int r = 0; r < 4; r++) begin
      add(qv(103), 0); add(qv(102), 0); add(qv(101), 0); add(qv(100), 0); add(NODEW, 0);
    end
    add(NODEW, 1);
    bus.root_valid = 0; bus.root_ptr = '0; bus.rd_req_ready = 1; bus.o_tready = 1;
    #1;
    chk("rst_tvalid", bus.o_tvalid, 1'b0);
    chk("rst_tlast", bus.o_tlast, 1'b0);
    chk("rst_tdata", bus.o_tdata, '0);
    chk("rst_req_valid", bus.rd_req_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_overflow, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 aresetn = 1;
    @(negedge clk);
    chk("ready_after_release", bus.root_ready, 1'b1);
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < ctab[c].nw; k++) expq.push_back(wtab[ctab[c].first + k]);
      addrq.delete();
      widx = 0;
      run(ctab[c].root, ctab[c].stall, ctab[c].ovf);
      chk("queue_drained", 66'(expq.size()), 66'd0);
      if (c == 1) begin
        chk("read_count", 66'(addrq.size()), 66'd5);
        if (addrq.size() == 5) for (int i = 0; i < 5; i++) chk("read_order", addrq[i], ea[i]);
      end
    end
    expq.delete();
    bus.o_tready = 0;
    @(posedge clk); #1;
    bus.root_valid = 1; bus.root_ptr = 10;
    @(posedge clk); #1;
    bus.root_valid = 0;
    cyc = 0;
    while (!bus.o_tvalid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_emit", bus.o_tvalid, 1'b1);
    #2 aresetn = 0;
    #1;
    chk("async_rst_tvalid", bus.o_tvalid, 1'b0);
    chk("async_rst_req", bus.rd_req_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_tdata", bus.o_tdata, '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    aresetn = 1; bus.o_tready = 1;
    @(negedge clk);
    chk("rerelease_ready", bus.root_ready, 1'b1);
    @(posedge clk); #1;
    inj_d = qv(99); inj_v = 1;
    @(posedge clk); #1;
    inj_v = 0;
    repeat (4) begin
      @(negedge clk);
      chk("late_rsp_tvalid", bus.o_tvalid, 1'b0);
      chk("late_rsp_busy", busy, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/qtree_int_stream_tx.md
Name: qtree_int_stream_tx

Overview:
Serializer for QTree Int structures held in the design's node heap. It takes a root pointer, walks the tree depth-first through a single-outstanding heap read port, and emits every node as one AXI-Stream word in post-order. This is the exact format the stream-to-heap loader consumes. The block sits on the result side of a DUT whose output is a QTree: the host loads input trees over AXI-Stream, and this block streams the result tree back.

Parameters:
PTR_W, 16, heap pointer/address width
VAL_W, 32, Int payload width
NODE_W, 66, node word width: [1:0] tag, then payload
DEPTH, 64, traversal stack entries (maximum QNode nesting)

Ports:
clk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
root_valid  in  1  root pointer offered
root_ready  out  1  block idle and accepting a root
root_ptr  in  PTR_W  heap address of tree root
rd_req_valid  out  1  heap read request
rd_req_ready  in  1  heap accepts request
rd_req_addr  out  PTR_W  heap read address
rd_rsp_valid  in  1  heap read data valid (one cycle)
rd_rsp_data  in  NODE_W  node word read
o_tdata  out  NODE_W  stream word
o_tvalid  out  1  stream valid
o_tready  in  1  stream ready
o_tlast  out  1  final word of tree (the root)
busy  out  1  traversal in progress
err_overflow  out  1  sticky: stack overflow aborted traversal

Behaviour:
- Reset: clk and aresetn are the only clock and reset. aresetn is asynchronous and active-low.
- Values while aresetn is low: state=IDLE, stack pointer=0, o_tvalid=0, o_tlast=0, o_tdata=0, rd_req_valid=0, busy=0, err_overflow=0. root_ready=1 from the first clock after release.
- Node encoding, tag [1:0]:
  - 0 = QNone.
  - 1 = QVal, value in [VAL_W+1:2].
  - 2 = QNode, children c0..c3 at [2+16k+15:2+16k] for k=0..3.
  - 3 = QError.
- States:
  - IDLE: root_ready=1. On root_valid, latch cur_ptr<=root_ptr, clear err_overflow, and go to FETCH.
  - FETCH: rd_req_valid=1, rd_req_addr=cur_ptr. When rd_req_ready=1, go to WAIT.
  - WAIT: rd_rsp_data is sampled only on rd_rsp_valid. rd_rsp_valid in any other state is ignored.
    - Tag 2: push {c0..c3, remaining=4}. If the stack is full, set err_overflow=1 and return to IDLE with no further words and no tlast. Otherwise go to NEXT.
    - Tags 0, 1 or 3: load o_tdata with the response word verbatim, then go to EMIT.
  - NEXT (top of stack):
    - If remaining>0: cur_ptr<=child[remaining-1], decrement remaining, go to FETCH. Children are therefore visited c3,c2,c1,c0, so c0 is the last subtree emitted before its parent.
    - If remaining==0: o_tdata<={zeros, 2'd2} (QNode word, pointer field zeroed; the receiver rebuilds pointers), pop, go to EMIT.
  - EMIT: o_tvalid=1, and o_tlast=1 if and only if the stack is empty. On o_tready: if tlast, go to IDLE; otherwise go to NEXT.
- Stream rules:
  - o_tdata, o_tlast and o_tvalid are held stable while o_tvalid=1 and o_tready=0.
  - No heap request is issued while a word is pending.
  - o_tvalid is never dropped without a handshake, except on reset.
- Latency:
  - Root accept to first rd_req_valid: 1 cycle.
  - Response to o_tvalid for a leaf: 1 cycle.
  - At most one heap request outstanding.
- busy=1 in every state except IDLE.
- root_valid while busy is not accepted (root_ready=0).
- Single-leaf tree: one word, tlast=1.
- Boundaries:
  - DEPTH nesting levels are legal. Level DEPTH+1 overflows.
  - The stack pointer never wraps.
- Reset mid-operation: abandons traversal and the stack immediately. An outstanding heap response arriving after release is ignored (IDLE).

Test Plan:
1. Single leaf: heap[5]=QVal 42, root_ptr=5 -> one word tag=1, value=42, tlast=1. root_ready=1 the cycle after the handshake.
2. One QNode at 10 with children 11..14 = QVal 1,2,3,4 -> 5 words in order: values 4,3,2,1, then tag=2 with payload 0 and tlast=1 on the fifth only. Reads in order 10,14,13,12,11.
3. Backpressure: hold o_tready=0 for 3 cycles on word 2 of scenario 2 -> o_tdata and o_tvalid stable, rd_req_valid=0 throughout, identical final stream.
4. Overflow: DEPTH=2 with three nested QNodes -> err_overflow=1, no tlast, FSM back in IDLE. Next root with a leaf -> err_overflow clears and the leaf is emitted normally.
5. Mixed leaves: QNode with children QNone, QError, QVal -7 (0xFFFFFFF9), QNone -> words carry tags 0,1,3,0 in order c3..c0, then the node word. Payload passed verbatim.
6. Reset mid-stream: drop aresetn during EMIT of scenario 2 -> o_tvalid=0 and rd_req_valid=0 asynchronously. After release: root_ready=1, and a late rd_rsp_valid pulse produces no output.
